// File: rtl/load_enable_skid_buffer_if.sv
// Handshake/data bundle for load_enable_skid_buffer: capture side (a, b),
// downstream valid/ready side (y), and status (stale_count, overflow).
interface load_enable_skid_buffer_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             in_ready;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic [CNT_W-1:0] stale_count;
    logic             overflow;
    logic             ovf_clr;

    modport master (
        output a, b, out_ready, ovf_clr,
        input  in_ready, out_valid, y, stale_count, overflow
    );

    modport slave (
        input  a, b, out_ready, ovf_clr,
        output in_ready, out_valid, y, stale_count, overflow
    );
endinterface

// File: rtl/load_enable_skid_buffer.sv
// Clocked load-enable capture stage feeding a 2-entry valid/ready buffer,
// with a saturating cycles-since-load counter and a sticky drop flag.
module load_enable_skid_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 4
) (
    input  logic                     clock,
    input  logic                     resetN,
    load_enable_skid_buffer_if.slave bus
);

    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_FULL  = 2'd2
    } occ_e;

    localparam logic [CNT_W-1:0] STALE_MAX = '1;

    occ_e             occ_q, occ_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] stale_q, stale_d;
    logic             ovf_q, ovf_d;

    logic req;
    logic push;
    logic pop;
    logic drop;
    logic in_ready;
    logic out_valid;

    assign in_ready  = (occ_q != OCC_FULL);
    assign out_valid = (occ_q != OCC_EMPTY);
    assign req       = |bus.b;
    assign push      = req & in_ready;
    assign pop       = out_valid & bus.out_ready;
    assign drop      = req & ~in_ready;

    // y_q is the head entry itself; tail_q only matters when full.
    always_comb begin
        occ_d  = occ_q;
        y_d    = y_q;
        tail_d = tail_q;
        case (occ_q)
            OCC_EMPTY: begin
                if (push) begin
                    y_d   = bus.a;
                    occ_d = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (push && pop) begin
                    y_d = bus.a;
                end else if (push) begin
                    tail_d = bus.a;
                    occ_d  = OCC_FULL;
                end else if (pop) begin
                    occ_d = OCC_EMPTY;
                end
            end
            OCC_FULL: begin
                if (pop) begin
                    y_d   = tail_q;
                    occ_d = OCC_ONE;
                end
            end
            default: begin
                occ_d = OCC_EMPTY;
            end
        endcase
    end

    always_comb begin
        stale_d = stale_q;
        if (push) begin
            stale_d = '0;
        end else if (stale_q != STALE_MAX) begin
            stale_d = stale_q + 1'b1;
        end
    end

    // A drop in the same cycle as ovf_clr keeps the flag set.
    always_comb begin
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (bus.ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            occ_q   <= OCC_EMPTY;
            y_q     <= '0;
            tail_q  <= '0;
            stale_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            occ_q   <= occ_d;
            y_q     <= y_d;
            tail_q  <= tail_d;
            stale_q <= stale_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.out_valid   = out_valid;
    assign bus.y           = y_q;
    assign bus.stale_count = stale_q;
    assign bus.overflow    = ovf_q;

endmodule
